// File: rtl/noc_pkg.sv
// Shared NoC link types: flit layout, flit types, packetizer FSM states, default widths.
// Header-flit payload occupies the low data bits left over after the X/Y destination fields.
package noc_pkg;

    localparam int NOC_DEST_X_W      = 4;
    localparam int NOC_DEST_Y_W      = 4;
    localparam int NOC_VC_NUM        = 2;
    localparam int NOC_VC_W          = $clog2(NOC_VC_NUM);
    localparam int FLIT_DATA_SIZE    = 32;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - NOC_DEST_X_W - NOC_DEST_Y_W;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_type_t;

    typedef struct packed {
        flit_type_t                flit_label;
        logic [NOC_VC_W-1:0]       vc_id;
        logic [FLIT_DATA_SIZE-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HEAD = 2'b01,
        ST_BODY = 2'b10
    } ni_state_t;

endpackage

// File: rtl/ni_credit_counter.sv
// Per-VC credit counter mirroring free slots in the router input buffer; loads BUFFER_SIZE on reset.
// Latency: inc/dec visible on is_zero the cycle after they are applied.
// Backpressure: is_zero gates the sender; inc and dec in the same cycle cancel.
module ni_credit_counter #(
    parameter int BUFFER_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic is_zero
);

    localparam int CNT_W = $clog2(BUFFER_SIZE + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= CNT_W'(BUFFER_SIZE);
        end else begin
            if (inc && !dec) begin
                assert (count < CNT_W'(BUFFER_SIZE)) else $error("credit overflow");
                count <= count + CNT_W'(1);
            end else if (dec && !inc) begin
                assert (count != '0) else $error("credit underflow");
                count <= count - CNT_W'(1);
            end
        end
    end

    assign is_zero = (count == '0);

endmodule

// File: rtl/ni_packetizer.sv
// NI transmitter: turns (dest, vc, len) messages plus payload words into HEAD/BODY/TAIL/HEADTAIL flits.
// Latency: payload handshake at cycle N gives valid_flit_o at N+1; one flit per cycle; optional NI_STATS_EN counters.
// Backpressure: data_ready_o drops while the packet's VC has zero registered credits; msg_ready_o only in IDLE.
module ni_packetizer
    import noc_pkg::*;
#(
    parameter int X_CURRENT        = 0,
    parameter int Y_CURRENT        = 0,
    parameter int DEST_ADDR_SIZE_X = NOC_DEST_X_W,
    parameter int DEST_ADDR_SIZE_Y = NOC_DEST_Y_W,
    parameter int VC_NUM           = NOC_VC_NUM,
    parameter int BUFFER_SIZE      = 8,
    parameter int MAX_PKT_LEN      = 15,
    localparam int VC_W            = $clog2(VC_NUM),
    localparam int LEN_W           = $clog2(MAX_PKT_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        msg_valid_i,
    output logic                        msg_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0] msg_x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0] msg_y_dest_i,
    input  logic [VC_W-1:0]             msg_vc_i,
    input  logic [LEN_W-1:0]            msg_len_i,
    input  logic                        data_valid_i,
    output logic                        data_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]   data_i,
    output flit_t                       flit_o,
    output logic                        valid_flit_o,
    input  logic                        credit_valid_i,
    input  logic [VC_W-1:0]             credit_vc_i
`ifdef NI_STATS_EN
    ,
    output logic [31:0]                 pkt_sent_o,
    output logic [31:0]                 flit_sent_o
`endif
);

    // Own coordinates are informational only; a packet to ourselves is routed LOCAL by the router.
    if (X_CURRENT >= (1 << DEST_ADDR_SIZE_X) || Y_CURRENT >= (1 << DEST_ADDR_SIZE_Y)) begin : g_bad_coord
        $error("node coordinates do not fit the destination fields");
    end
    if (DEST_ADDR_SIZE_X != NOC_DEST_X_W || DEST_ADDR_SIZE_Y != NOC_DEST_Y_W || VC_NUM != NOC_VC_NUM) begin : g_bad_cfg
        $error("packetizer widths disagree with noc_pkg flit layout");
    end

    ni_state_t                   state_q, state_d;
    logic [DEST_ADDR_SIZE_X-1:0] x_q;
    logic [DEST_ADDR_SIZE_Y-1:0] y_q;
    logic [VC_W-1:0]             vc_q;
    logic [LEN_W-1:0]            rem_q;
    logic [LEN_W-1:0]            len_clamped;
    logic [VC_NUM-1:0]           vc_zero;
    logic                        msg_fire, data_fire;
    flit_t                       flit_d;

    assign msg_fire    = msg_valid_i && msg_ready_o;
    assign data_fire   = data_valid_i && data_ready_o;
    assign len_clamped = (int'(msg_len_i) > MAX_PKT_LEN) ? LEN_W'(MAX_PKT_LEN) : msg_len_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (msg_fire) state_d = ST_HEAD;
            ST_HEAD: if (data_fire) state_d = (rem_q == '0) ? ST_IDLE : ST_BODY;
            ST_BODY: if (data_fire && rem_q == LEN_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // rst_n gating keeps both handshakes low while reset is held.
    always_comb begin
        msg_ready_o       = 1'b0;
        data_ready_o      = 1'b0;
        flit_d.flit_label = BODY;
        flit_d.vc_id      = vc_q;
        flit_d.data       = data_i;
        case (state_q)
            ST_IDLE: msg_ready_o = rst_n;
            ST_HEAD: begin
                data_ready_o      = rst_n && !vc_zero[vc_q];
                flit_d.flit_label = (rem_q == '0) ? HEADTAIL : HEAD;
                flit_d.data       = {x_q, y_q, data_i[HEAD_PAYLOAD_SIZE-1:0]};
            end
            ST_BODY: begin
                data_ready_o      = rst_n && !vc_zero[vc_q];
                flit_d.flit_label = (rem_q == LEN_W'(1)) ? TAIL : BODY;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q          <= '0;
            y_q          <= '0;
            vc_q         <= '0;
            rem_q        <= '0;
            flit_o       <= '0;
            valid_flit_o <= 1'b0;
        end else begin
            valid_flit_o <= data_fire;
            if (msg_fire) begin
                assert (int'(msg_len_i) <= MAX_PKT_LEN) else $error("msg_len_i above MAX_PKT_LEN, clamped");
                x_q   <= msg_x_dest_i;
                y_q   <= msg_y_dest_i;
                vc_q  <= msg_vc_i;
                rem_q <= len_clamped;
            end
            if (data_fire) begin
                flit_o <= flit_d;
                if (state_q == ST_BODY) rem_q <= rem_q - LEN_W'(1);
            end
        end
    end

    for (genvar v = 0; v < VC_NUM; v++) begin : g_cred
        ni_credit_counter #(
            .BUFFER_SIZE(BUFFER_SIZE)
        ) u_cnt (
            .clk    (clk),
            .rst_n  (rst_n),
            .inc    (credit_valid_i && credit_vc_i == VC_W'(v)),
            .dec    (data_fire && vc_q == VC_W'(v)),
            .is_zero(vc_zero[v])
        );
    end

`ifdef NI_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_sent_o  <= '0;
            flit_sent_o <= '0;
        end else if (data_fire) begin
            flit_sent_o <= flit_sent_o + 32'd1;
            if (flit_d.flit_label == TAIL || flit_d.flit_label == HEADTAIL)
                pkt_sent_o <= pkt_sent_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ni_packetizer.sv
// Bench for ni_packetizer: directed scenarios plus random packets against a flit-list / credit-count model.
module tb_ni_packetizer;
    import noc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        msg_valid = 1'b0;
    logic        msg_ready;
    logic [3:0]  msg_x = '0;
    logic [3:0]  msg_y = '0;
    logic [0:0]  msg_vc = '0;
    logic [3:0]  msg_len = '0;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [31:0] data = '0;
    flit_t       flit;
    logic        flit_vld;
    logic        credit_valid = 1'b0;
    logic [0:0]  credit_vc = '0;
`ifdef NI_STATS_EN
    logic [31:0] pkt_sent, flit_sent;
`endif

    int total = 0;
    int bad = 0;
    int cred[2];
    int exp_pkts = 0;
    int exp_flits = 0;
    int stall_total = 0;

    ni_packetizer #(
        .X_CURRENT(3), .Y_CURRENT(2), .DEST_ADDR_SIZE_X(4), .DEST_ADDR_SIZE_Y(4),
        .VC_NUM(2), .BUFFER_SIZE(8), .MAX_PKT_LEN(15)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .msg_valid_i(msg_valid), .msg_ready_o(msg_ready),
        .msg_x_dest_i(msg_x), .msg_y_dest_i(msg_y), .msg_vc_i(msg_vc), .msg_len_i(msg_len),
        .data_valid_i(data_valid), .data_ready_o(data_ready), .data_i(data),
        .flit_o(flit), .valid_flit_o(flit_vld),
        .credit_valid_i(credit_valid), .credit_vc_i(credit_vc)
`ifdef NI_STATS_EN
        , .pkt_sent_o(pkt_sent), .flit_sent_o(flit_sent)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_credits();
        chk("credits_vc0", 64'(dut.g_cred[0].u_cnt.count), 64'(cred[0]));
        chk("credits_vc1", 64'(dut.g_cred[1].u_cnt.count), 64'(cred[1]));
    endtask

    task automatic chk_stats();
`ifdef NI_STATS_EN
        chk("pkt_sent", 64'(pkt_sent), 64'(exp_pkts));
        chk("flit_sent", 64'(flit_sent), 64'(exp_flits));
`endif
    endtask

    // Expected flit as a flat number: type above vc above 32-bit data; head carries x,y in the top byte.
    function automatic logic [63:0] exp_flit(input flit_type_t typ, input int vc, input int x,
                                             input int y, input logic [31:0] w, input bit head);
        logic [63:0] d;
        d = head ? ((64'(x) << 28) | (64'(y) << 24) | (64'(w) & 64'h00FF_FFFF)) : 64'(w);
        return (64'(typ) << 33) | (64'(vc) << 32) | d;
    endfunction

    task automatic send_msg(input int x, input int y, input int vc, input int len);
        for (int n = 0; n < 20 && !msg_ready; n++) tick();
        chk("msg_ready_idle", 64'(msg_ready), 64'd1);
        msg_valid = 1'b1;
        msg_x = 4'(x);
        msg_y = 4'(y);
        msg_vc = 1'(vc);
        msg_len = 4'(len);
        tick();
        msg_valid = 1'b0;
        chk("msg_ready_busy", 64'(msg_ready), 64'd0);
    endtask

    // Offers one word; when the VC runs dry it waits a few cycles, then returns one credit itself.
    task automatic send_word(input logic [31:0] w, input logic [63:0] exp, input int vc,
                             input bit ret_en, input int ret_vc);
        bit fired = 0;
        int stall = 0;
        data_valid = 1'b1;
        data = w;
        for (int c = 0; c < 40 && !fired; c++) begin
            if (data_ready) begin
                chk("ready_has_credit", 64'(cred[vc] > 0), 64'd1);
                credit_valid = ret_en;
                credit_vc = 1'(ret_vc);
                tick();
                credit_valid = 1'b0;
                cred[vc]--;
                if (ret_en) cred[ret_vc]++;
                exp_flits++;
                chk("flit_valid", 64'(flit_vld), 64'd1);
                chk("flit", 64'(flit), exp);
                chk_credits();
                fired = 1;
            end else begin
                chk("stall_means_no_credit", 64'(cred[vc]), 64'd0);
                stall_total++;
                if (stall >= 3) begin
                    credit_valid = 1'b1;
                    credit_vc = 1'(vc);
                    tick();
                    credit_valid = 1'b0;
                    cred[vc]++;
                    stall = 0;
                end else begin
                    tick();
                    stall++;
                end
                chk("no_flit_while_stalled", 64'(flit_vld), 64'd0);
            end
        end
        if (!fired) chk("word_timeout", 64'd0, 64'd1);
        data_valid = 1'b0;
    endtask

    task automatic send_pkt(input int x, input int y, input int vc, input int len,
                            input logic [31:0] w_first, input bit ret_en, input int ret_vc);
        logic [31:0] w;
        logic [63:0] e;
        flit_type_t typ;
        send_msg(x, y, vc, len);
        for (int i = 0; i <= len; i++) begin
            w = (i == 0) ? w_first : $urandom;
            if (len == 0) typ = HEADTAIL;
            else if (i == 0) typ = HEAD;
            else if (i == len) typ = TAIL;
            else typ = BODY;
            e = exp_flit(typ, vc, x, y, w, i == 0);
            send_word(w, e, vc, ret_en, ret_vc);
        end
        exp_pkts++;
        tick();
        chk("valid_drops_after_pkt", 64'(flit_vld), 64'd0);
        chk("flit_holds_last", 64'(flit), e);
        chk_stats();
    endtask

    task automatic restore_credits();
        for (int v = 0; v < 2; v++) begin
            while (cred[v] < 8) begin
                credit_valid = 1'b1;
                credit_vc = 1'(v);
                tick();
                cred[v]++;
            end
            credit_valid = 1'b0;
        end
        chk_credits();
    endtask

    initial begin
        cred[0] = 8;
        cred[1] = 8;

        // Reset state
        tick();
        tick();
        chk("rst_msg_ready", 64'(msg_ready), 64'd0);
        chk("rst_data_ready", 64'(data_ready), 64'd0);
        chk("rst_flit_valid", 64'(flit_vld), 64'd0);
        chk("rst_flit", 64'(flit), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_msg_ready", 64'(msg_ready), 64'd1);
        chk_credits();
        chk_stats();

        // Single-word HEADTAIL
        send_pkt(2, 1, 0, 0, 32'h0000_00A5, 0, 0);
        // Four-flit packet on consecutive cycles
        send_pkt(5, 7, 1, 3, $urandom, 0, 0);
        restore_credits();

        // Credit exhaustion: 12 flits against 8 credits forces stalls after the eighth
        send_pkt(9, 4, 0, 11, $urandom, 0, 0);
        chk("stalled_on_credits", 64'(stall_total > 0), 64'd1);
        restore_credits();

        // Credit return on the other VC, then simultaneous return on the sending VC
        send_pkt(1, 1, 1, 2, $urandom, 0, 0);
        send_pkt(6, 3, 0, 2, $urandom, 1, 1);
        send_pkt(6, 3, 0, 2, $urandom, 1, 0);
        restore_credits();

        // Reset after the head of a 6-flit packet
        send_msg(4, 4, 0, 5);
        send_word(32'h1234_5678, exp_flit(HEAD, 0, 4, 4, 32'h1234_5678, 1), 0, 0, 0);
        rst_n = 1'b0;
        tick();
        cred[0] = 8;
        cred[1] = 8;
        exp_pkts = 0;
        exp_flits = 0;
        chk("midrst_msg_ready", 64'(msg_ready), 64'd0);
        chk("midrst_data_ready", 64'(data_ready), 64'd0);
        chk("midrst_flit_valid", 64'(flit_vld), 64'd0);
        chk("midrst_flit", 64'(flit), 64'd0);
        chk_credits();
        chk_stats();
        rst_n = 1'b1;
        #1;
        chk("after_midrst_msg_ready", 64'(msg_ready), 64'd1);
        tick();

        // Destination equals own coordinates
        send_pkt(3, 2, 1, 1, $urandom, 0, 0);

        // Random packets; credits are only sometimes topped up
        for (int p = 0; p < 10; p++) begin
            send_pkt($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1),
                     $urandom_range(0, 15), $urandom, 0, 0);
            if ($urandom_range(0, 1) == 1) restore_credits();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
